hs_tx_arbiter: RTL and testbench
================================

# hs_tx_arbiter

Round-robin arbiter and four-phase sequencer that shares one cross-clock req/ack data link between NREQ local requesters. It sits in the clk_a domain in front of the link, in place of a single dedicated driver. It grants one requester at a time, registers its data, and runs the complete req↑/ack↑/req↓/ack↓ cycle against a receiver in another clock domain. It then reports completion to the requester that was granted.

## Interface
- NREQ, 4: number of requesters, 2..16
- DW, 4: data width
- TIMEOUT, 255: REQ-state wait limit in clk_a cycles; used only with the macro
- clk_a  in  1  sole clock
- rst_n  in  1  asynchronous, active-low reset
- src_valid  in  NREQ  per-requester level request; held until its src_done
- src_data  in  NREQ*DW  requester i occupies bits [i*DW +: DW]
- src_done  out  NREQ  one-hot, one-cycle completion pulse
- data_ack  in  1  ack from receiver domain, asynchronous to clk_a
- data  out  DW  registered link data
- data_req  out  1  registered link request
- busy  out  1  high in every state except IDLE
- grant_id  out  $clog2(NREQ)  index of the current or last granted requester
- timeout_err  out  1  one-cycle pulse on abort; tied 0 without the macro

## Operation
- data_ack passes through a 2-flop synchronizer to produce ack_s. No other use of raw data_ack.
- FSM states:
  - IDLE
    - Grant only when ack_s==0 and at least one eligible requester exists.
    - Eligible means src_valid[i]==1 and src_done[i]==0. This masks the requester currently pulsing done, so it cannot be re-granted on the same edge.
    - Winner is the first eligible index searching upward from ptr, wrapping modulo NREQ.
    - On grant: data<=src_data[winner], grant_id<=winner, go to SETUP.
  - SETUP: data_req<=1, go to REQ. This gives one cycle of data setup before req rises.
  - REQ: wait for ack_s==1, then data_req<=0 and go to RELEASE.
  - RELEASE:
    - Wait for ack_s==0.
    - Then src_done[grant_id]<=1 for one cycle, ptr<=(grant_id+1) mod NREQ, go to IDLE.
- data changes only on the IDLE→SETUP edge. It is stable from SETUP through the exit from RELEASE.
- Deassertion of src_valid after grant is ignored. The transfer completes and src_done still pulses.
- Reset values: data=0, data_req=0, src_done=0, busy=0, grant_id=0, timeout_err=0, ptr=0, sync flops=0, state=IDLE.
- Reset mid-handshake: all outputs drop immediately.
  - The IDLE grant rule (ack_s==0) keeps the block from starting a new cycle while the receiver's ack from the aborted cycle is still high.

## Timing
- Grant: src_valid sampled in IDLE at edge k → data and grant_id valid after k. data_req rises after k+1.
- ack edge → ack_s: 2 clk_a edges.
  - data_req falls at the edge after ack_s rises.
  - src_done pulses at the edge after ack_s falls.
- Back-to-back transfers: IDLE lasts at least 1 cycle between a src_done pulse and the next SETUP.
- Minimum transaction length: 4 FSM cycles plus 2×(receiver response + 2 sync cycles).
- Fairness: each eligible requester is granted within NREQ transactions.

## Configuration
- HS_ARB_TIMEOUT_EN defined:
  - A counter runs in REQ and clears on entry to REQ.
  - If it reaches TIMEOUT with ack_s still 0, then on that edge: data_req<=0, timeout_err pulses for one cycle, state goes to RELEASE.
  - src_done pulses normally on exit from RELEASE. The requester treats the transfer as failed if timeout_err pulsed during that transaction.
- HS_ARB_TIMEOUT_EN undefined: REQ waits indefinitely, no counter logic is present, timeout_err is constant 0.

## Structure
- Package hs_arb_pkg holds:
  - state enum typedef: IDLE, SETUP, REQ, RELEASE
  - default width constants
  - $clog2-based width helper for grant_id and ptr
- Sub-module hs_rr_pick (combinational):
  - inputs: eligible vector, ptr
  - outputs: winner index and a found flag
  - It is reused by other arbiters in the design.

## Test plan
- Single requester: src_valid=4'b0001, src_data[0]=4'hA, receiver acks 3 cycles after req → data=4'hA before req↑. src_done=4'b0001 pulses once. data is unchanged throughout.
- Contention: all four valid with data 1,2,3,4, valid held until each requester's own done → grant order 0,1,2,3. Outputs 1,2,3,4 in that order.
- Round-robin wrap: after requester 2 completes, requesters 1 and 3 valid → 3 is granted first, then 1.
- Re-request: requester 0 keeps valid high across its own done, requester 1 also valid → next grant goes to 1, not 0.
- Reset mid-operation: assert rst_n=0 in REQ with ack high → all outputs 0. After release, no new data_req until synchronized ack is low.
- With HS_ARB_TIMEOUT_EN and TIMEOUT=8: receiver never acks → data_req falls 8 cycles after entering REQ. timeout_err pulses once and src_done pulses, then the next requester is served.

Source files
------------

// File: rtl/hs_arb_pkg.sv
// Shared types and width helpers for the hs_tx_arbiter slice.
package hs_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        REQ     = 2'd2,
        RELEASE = 2'd3
    } hs_state_e;

    localparam int NREQ_DEF    = 4;
    localparam int DW_DEF      = 4;
    localparam int TIMEOUT_DEF = 255;

    // Index width for a vector of n entries; never below 1 bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hs_rr_pick.sv
// Combinational round-robin picker: first set bit of eligible at or above ptr, wrapping.
module hs_rr_pick
    import hs_arb_pkg::*;
#(
    parameter int N  = NREQ_DEF,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  eligible,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] winner,
    output logic          found
);

    logic [IW:0] sum;

    // Scan offsets from far to near so the nearest eligible index wins last.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        sum    = '0;
        for (int k = N - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (IW + 1)'(k);
            if (sum >= (IW + 1)'(N)) begin
                sum = sum - (IW + 1)'(N);
            end
            if (eligible[sum[IW-1:0]]) begin
                winner = sum[IW-1:0];
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hs_tx_arbiter.sv
// Round-robin arbiter and four-phase req/ack sequencer sharing one cross-clock link.
// Define HS_ARB_TIMEOUT_EN to add the REQ-state watchdog driving timeout_err.
//
// state   | meaning
// IDLE    | waiting for an eligible requester with synchronized ack low
// SETUP   | data registered, one cycle of setup before req rises
// REQ     | data_req high, waiting for synchronized ack high
// RELEASE | data_req low, waiting for synchronized ack low, then src_done
module hs_tx_arbiter
    import hs_arb_pkg::*;
#(
    parameter int NREQ    = NREQ_DEF,
    parameter int DW      = DW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF,
    localparam int IW     = idx_w(NREQ)
) (
    input  logic                 clk_a,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      src_valid,
    input  logic [NREQ*DW-1:0]   src_data,
    output logic [NREQ-1:0]      src_done,
    input  logic                 data_ack,
    output logic [DW-1:0]        data,
    output logic                 data_req,
    output logic                 busy,
    output logic [IW-1:0]        grant_id,
    output logic                 timeout_err
);

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("hs_tx_arbiter: TIMEOUT must be at least 1");
    end

    hs_state_e       state;
    logic [IW-1:0]   ptr;
    logic            ack_m;
    logic            ack_s;
    logic [NREQ-1:0] eligible;
    logic [IW-1:0]   winner;
    logic            found;
    logic [DW-1:0]   src_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_split
        assign src_arr[i] = src_data[i*DW +: DW];
    end

    always_ff @(posedge clk_a or negedge rst_n) begin
        if (!rst_n) begin
            ack_m <= 1'b0;
            ack_s <= 1'b0;
        end else begin
            ack_m <= data_ack;
            ack_s <= ack_m;
        end
    end

    // The requester pulsing done this cycle must not win again on the same edge.
    assign eligible = src_valid & ~src_done;

    hs_rr_pick #(.N(NREQ), .IW(IW)) u_pick (
        .eligible (eligible),
        .ptr      (ptr),
        .winner   (winner),
        .found    (found)
    );

`ifdef HS_ARB_TIMEOUT_EN
    localparam int TW = idx_w(TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit;

    assign tmo_hit = (state == REQ) && !ack_s && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk_a or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= tmo_hit;
            tmo_cnt     <= (state == REQ) ? tmo_cnt + 1'b1 : '0;
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk_a or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            data     <= '0;
            data_req <= 1'b0;
            src_done <= '0;
            busy     <= 1'b0;
            grant_id <= '0;
            ptr      <= '0;
        end else begin
            src_done <= '0;
            case (state)
                IDLE: begin
                    if (!ack_s && found) begin
                        data     <= src_arr[winner];
                        grant_id <= winner;
                        busy     <= 1'b1;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    data_req <= 1'b1;
                    state    <= REQ;
                end
                REQ: begin
                    if (ack_s) begin
                        data_req <= 1'b0;
                        state    <= RELEASE;
                    end
`ifdef HS_ARB_TIMEOUT_EN
                    else if (tmo_hit) begin
                        data_req <= 1'b0;
                        state    <= RELEASE;
                    end
`endif
                end
                RELEASE: begin
                    if (!ack_s) begin
                        src_done[grant_id] <= 1'b1;
                        ptr   <= (grant_id == IW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hs_tx_arbiter.sv
// Directed scoreboard bench for hs_tx_arbiter with a behavioural four-phase receiver.
module tb_hs_tx_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 4;
    localparam int IW   = $clog2(NREQ);

    logic                clk_a = 1'b0;
    logic                rst_n = 1'b0;
    logic [NREQ-1:0]     src_valid = '0;
    logic [NREQ*DW-1:0]  src_data = '0;
    logic [NREQ-1:0]     src_done;
    logic                data_ack = 1'b0;
    logic [DW-1:0]       data;
    logic                data_req;
    logic                busy;
    logic [IW-1:0]       grant_id;
    logic                timeout_err;

    int n_vec = 0;
    int n_err = 0;
    bit rx_en = 1'b0;
    int rx_dly = 3;
    int rx_cnt = 0;
    int tmo_pulses = 0;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [DW-1:0] d;
        logic          drop;
    } exp_t;

    exp_t exp_q[$];

    hs_tx_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(8)) dut (
        .clk_a       (clk_a),
        .rst_n       (rst_n),
        .src_valid   (src_valid),
        .src_data    (src_data),
        .src_done    (src_done),
        .data_ack    (data_ack),
        .data        (data),
        .data_req    (data_req),
        .busy        (busy),
        .grant_id    (grant_id),
        .timeout_err (timeout_err)
    );

    always #5 clk_a = ~clk_a;

    // Receiver: follows data_req with data_ack after rx_dly clk_a cycles.
    initial begin
        forever begin
            @(negedge clk_a);
            if (rx_en) begin
                if (data_req !== data_ack) begin
                    rx_cnt++;
                    if (rx_cnt >= rx_dly) begin
                        data_ack = data_req;
                        rx_cnt   = 0;
                    end
                end else begin
                    rx_cnt = 0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk_a);
            if (timeout_err === 1'b1) tmo_pulses++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic set_data(input int i, input logic [DW-1:0] v);
        src_data[i*DW +: DW] = v;
    endtask

    task automatic push_exp(input int id, input logic [DW-1:0] d, input bit drop);
        exp_t e;
        e.id   = IW'(id);
        e.d    = d;
        e.drop = drop;
        exp_q.push_back(e);
    endtask

    task automatic reset_dut();
        rx_en    = 1'b0;
        data_ack = 1'b0;
        rx_cnt   = 0;
        rst_n    = 1'b0;
        repeat (2) @(negedge clk_a);
        rst_n = 1'b1;
        @(negedge clk_a);
        rx_en = 1'b1;
    endtask

    task automatic wait_done(input string tag);
        exp_t            e;
        logic [DW-1:0]   d0;
        logic [NREQ-1:0] dv;
        bit              seen;
        bit              stable;
        seen   = 1'b0;
        stable = 1'b1;
        dv     = '0;
        d0     = '0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk_a);
            if (data_req === 1'b1 && !seen) begin
                seen = 1'b1;
                d0   = data;
            end else if (seen && data !== d0) begin
                stable = 1'b0;
            end
            if (src_done !== '0) begin
                dv = src_done;
                break;
            end
        end
        if (exp_q.size() == 0) begin
            n_err++;
            $error("FAIL %s: no expected entry queued", tag);
            return;
        end
        e = exp_q.pop_front();
        check({tag, "_done"},   32'(dv),       32'(1) << e.id);
        check({tag, "_gid"},    32'(grant_id), 32'(e.id));
        check({tag, "_data"},   32'(d0),       32'(e.d));
        check({tag, "_stable"}, 32'(stable),   32'(seen));
        check({tag, "_busy"},   32'(busy),     32'(0));
        check({tag, "_req"},    32'(data_req), 32'(0));
        if (e.drop) src_valid[e.id] = 1'b0;
        @(negedge clk_a);
        check({tag, "_pulse1"}, 32'(src_done), 32'(0));
    endtask

    initial begin
        bit quiet;
        int n;

        // Reset state
        repeat (2) @(negedge clk_a);
        check("rst_data",  32'(data),        32'(0));
        check("rst_req",   32'(data_req),    32'(0));
        check("rst_done",  32'(src_done),    32'(0));
        check("rst_busy",  32'(busy),        32'(0));
        check("rst_gid",   32'(grant_id),    32'(0));
        check("rst_tmo",   32'(timeout_err), 32'(0));
        reset_dut();

        // Single requester
        rx_dly = 3;
        set_data(0, 4'hA);
        push_exp(0, 4'hA, 1'b1);
        src_valid = 4'b0001;
        wait_done("single");

        // Contention from ptr=0
        reset_dut();
        rx_dly = 1;
        for (int i = 0; i < NREQ; i++) begin
            set_data(i, DW'(i + 1));
            push_exp(i, DW'(i + 1), 1'b1);
        end
        src_valid = 4'b1111;
        for (int i = 0; i < NREQ; i++) wait_done("cont");

        // Round-robin wrap
        rx_dly = 5;
        set_data(2, 4'h5);
        push_exp(2, 4'h5, 1'b1);
        src_valid = 4'b0100;
        wait_done("wrap_a");
        set_data(1, 4'h6);
        set_data(3, 4'h7);
        push_exp(3, 4'h7, 1'b1);
        push_exp(1, 4'h6, 1'b1);
        src_valid = 4'b1010;
        wait_done("wrap_b");
        wait_done("wrap_c");

        // Re-request: 0 keeps valid across its done, 1 must go next
        rx_dly = 2;
        set_data(0, 4'h8);
        set_data(1, 4'h3);
        push_exp(0, 4'h8, 1'b0);
        push_exp(1, 4'h3, 1'b1);
        push_exp(0, 4'h8, 1'b1);
        src_valid = 4'b0011;
        wait_done("rereq_a");
        wait_done("rereq_b");
        wait_done("rereq_c");

        // Reset in REQ with ack high
        reset_dut();
        rx_en = 1'b0;
        set_data(0, 4'h9);
        src_valid = 4'b0001;
        quiet = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_a);
            if (data_req === 1'b1) begin
                quiet = 1'b1;
                break;
            end
        end
        check("mid_req_seen", 32'(quiet), 32'(1));
        data_ack = 1'b1;
        @(negedge clk_a);
        rst_n     = 1'b0;
        src_valid = '0;
        #1;
        check("mid_rst_outs", 32'({data, data_req, src_done, busy, grant_id, timeout_err}), 32'(0));
        @(negedge clk_a);
        rst_n = 1'b1;
        repeat (3) @(negedge clk_a);
        src_valid = 4'b0001;
        quiet = 1'b1;
        repeat (8) begin
            @(negedge clk_a);
            if (data_req !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
        end
        check("mid_quiet", 32'(quiet), 32'(1));
        data_ack = 1'b0;
        rx_cnt   = 0;
        rx_dly   = 3;
        rx_en    = 1'b1;
        push_exp(0, 4'h9, 1'b1);
        wait_done("mid_resume");

`ifdef HS_ARB_TIMEOUT_EN
        // Watchdog: receiver silent, data_req must fall 8 cycles into REQ
        reset_dut();
        rx_en      = 1'b0;
        tmo_pulses = 0;
        set_data(0, 4'h6);
        set_data(1, 4'h7);
        src_valid = 4'b0011;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_a);
            if (data_req === 1'b1) break;
        end
        n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_a);
            n++;
            if (data_req === 1'b0) break;
        end
        check("tmo_len", 32'(n), 32'(8));
        for (int c = 0; c < 20; c++) begin
            if (src_done !== '0) break;
            @(negedge clk_a);
        end
        check("tmo_done", 32'(src_done), 32'(1));
        src_valid[0] = 1'b0;
        rx_cnt = 0;
        rx_en  = 1'b1;
        push_exp(1, 4'h7, 1'b1);
        wait_done("tmo_next");
        check("tmo_pulses", 32'(tmo_pulses), 32'(1));
`else
        check("no_tmo", 32'(tmo_pulses), 32'(0));
`endif

        check("queue_empty", 32'(exp_q.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
